chaos_key_extractor: RTL



---
 rtl/chaos_key_extractor_if.sv | 24 ++
 rtl/chaos_key_extractor.sv | 132 +++++++++++++
 2 files changed

// File: rtl/chaos_key_extractor_if.sv
// Handshake bundle for chaos_key_extractor: sample groups in, key groups out.
// master drives samples and out_ready; slave is the extractor.
interface chaos_key_extractor_if #(
  parameter int NCH   = 3,
  parameter int KEY_W = 10
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*32-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*KEY_W-1:0] out_key;
  logic [NCH-1:0]       out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_key, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_key, out_err
  );
endinterface

// File: rtl/chaos_key_extractor.sv
// Four-stage float-to-key extractor: floor(|v|*SCALE) mod MODULUS per channel.
// Define CHAOS_KEY_FOLD_EN to add the registered XOR-folded byte key fold_key.
module chaos_key_extractor #(
  parameter int NCH     = 3,
  parameter int SCALE   = 1000,
  parameter int MODULUS = 1000,
  parameter int KEY_W   = 10
) (
  input  logic clk,
  input  logic rst_n,
  chaos_key_extractor_if.slave bus
`ifdef CHAOS_KEY_FOLD_EN
  ,
  output logic [7:0] fold_key
`endif
);

  localparam int QW = 55;
  localparam int PW = 32 + $clog2(SCALE);
  localparam int XW = QW + $clog2(SCALE) + 1;

  logic adv;
  logic s1_v, s2_v, s3_v, s4_v;

  logic [NCH-1:0][7:0]       s1_e;
  logic [NCH-1:0][22:0]      s1_f;
  logic [NCH-1:0][QW-1:0]    s2_q, q_nxt;
  logic [NCH-1:0]            s2_err, err_nxt;
  logic [NCH-1:0][PW-1:0]    s3_p, p_nxt;
  logic [NCH-1:0]            s3_err;
  logic [NCH-1:0][KEY_W-1:0] s4_key, key_nxt;
  logic [NCH-1:0]            s4_err;
  logic                      unused_sign;

  assign adv           = !s4_v || bus.out_ready;
  assign bus.in_ready  = !rst_n || adv;
  assign bus.out_valid = s4_v;
  assign bus.out_key   = s4_key;
  assign bus.out_err   = s4_err;

  // Q32.23 magnitude; fraction bits below 2^-23 fall off the right shift
  function automatic logic [QW-1:0] magnitude(
    input logic [7:0]  e,
    input logic [22:0] f
  );
    logic [QW-1:0] m;
    logic [7:0]    rsh;
    m   = QW'({e != 8'd0, f});
    rsh = (e == 8'd0) ? 8'd126 : 8'd127 - e;
    if (e >= 8'd127)
      magnitude = m << (e - 8'd127);
    else
      magnitude = m >> rsh;
  endfunction

  always_comb begin
    unused_sign = 1'b0;
    for (int i = 0; i < NCH; i++)
      unused_sign = unused_sign ^ bus.in_data[32*i+31];
  end

  always_comb begin
    q_nxt   = '0;
    err_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      err_nxt[i] = (s1_e[i] == 8'hFF) || (s1_e[i] >= 8'd159);
      q_nxt[i]   = err_nxt[i] ? '0 : magnitude(s1_e[i], s1_f[i]);
    end
  end

  always_comb begin
    p_nxt = '0;
    for (int i = 0; i < NCH; i++)
      p_nxt[i] = PW'((XW'(s2_q[i]) * XW'(SCALE)) >> 23);
  end

  always_comb begin
    key_nxt = '0;
    for (int i = 0; i < NCH; i++)
      key_nxt[i] = KEY_W'(s3_p[i] % PW'(MODULUS));
  end

`ifdef CHAOS_KEY_FOLD_EN
  logic [7:0] fold_nxt;

  always_comb begin
    fold_nxt = '0;
    for (int i = 0; i < NCH; i++)
      fold_nxt = fold_nxt ^ 8'(key_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      fold_key <= '0;
    else if (adv)
      fold_key <= fold_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s3_v   <= 1'b0;
      s4_v   <= 1'b0;
      s1_e   <= '0;
      s1_f   <= '0;
      s2_q   <= '0;
      s2_err <= '0;
      s3_p   <= '0;
      s3_err <= '0;
      s4_key <= '0;
      s4_err <= '0;
    end else if (adv) begin
      s1_v <= bus.in_valid;
      s2_v <= s1_v;
      s3_v <= s2_v;
      s4_v <= s3_v;
      for (int i = 0; i < NCH; i++) begin
        s1_e[i] <= bus.in_data[32*i+23 +: 8];
        s1_f[i] <= bus.in_data[32*i +: 23];
      end
      s2_q   <= q_nxt;
      s2_err <= err_nxt;
      s3_p   <= p_nxt;
      s3_err <= s2_err;
      s4_key <= key_nxt;
      s4_err <= s3_err;
    end
  end

endmodule
